// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type and sizing constants for the Wishbone round-robin arbiter.
package wb_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_t;
   localparam int OUTSTANDING_W   = 4;
   localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first requester after last in cyclic ascending order.
module rr_pick #(
   parameter int N  = 3,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  win
);
   logic [N-1:0] hi_win, lo_win;

   // descending scan leaves the lowest matching index in each candidate
   always_comb begin
      hi_win = '0;
      lo_win = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_win    = '0;
            lo_win[j] = 1'b1;
         end
         if (req[j] && j > int'(last)) begin
            hi_win    = '0;
            hi_win[j] = 1'b1;
         end
      end
   end

   assign win = |hi_win ? hi_win : lo_win;
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master pipelined Wishbone round-robin arbiter with outstanding tracking
// and a slave-response timeout that aborts the owner's cycle with an error.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_MASTERS-1:0]       m_cyc,
   input  logic [NUM_MASTERS-1:0]       m_stb,
   input  logic [NUM_MASTERS-1:0]       m_we,
   input  logic [NUM_MASTERS-1:0][31:0] m_adr,
   input  logic [NUM_MASTERS-1:0][31:0] m_dat_w,
   input  logic [NUM_MASTERS-1:0][3:0]  m_sel,
   output logic [NUM_MASTERS-1:0]       m_stall,
   output logic [NUM_MASTERS-1:0]       m_ack,
   output logic [NUM_MASTERS-1:0]       m_err,
   output logic [31:0]                  m_dat_r,
   output logic                         s_cyc,
   output logic                         s_stb,
   output logic                         s_we,
   output logic [31:0]                  s_adr,
   output logic [31:0]                  s_dat_w,
   output logic [3:0]                   s_sel,
   input  logic                         s_stall,
   input  logic                         s_ack,
   input  logic                         s_err,
   input  logic [31:0]                  s_dat_r,
   output logic [NUM_MASTERS-1:0]       grant,
   output logic                         timeout_pulse
);
   localparam int LW = $clog2(NUM_MASTERS);
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

   arb_state_t               state;
   logic [LW-1:0]            owner, last_owner, pick_idx;
   logic [NUM_MASTERS-1:0]   pick;
   logic [OUTSTANDING_W-1:0] outstanding;
   logic [TW-1:0]            tcount;
   logic                     busy, abort, own_cyc, resp, inc, dec;

   rr_pick #(.N(NUM_MASTERS)) u_pick (.req(m_cyc), .last(last_owner), .win(pick));

   always_comb begin
      pick_idx = '0;
      for (int j = 0; j < NUM_MASTERS; j++)
         if (pick[j]) pick_idx = j[LW-1:0];
   end

   assign busy    = state == BUSY;
   assign abort   = state == ABORT;
   assign own_cyc = m_cyc[owner];
   assign s_cyc   = busy & own_cyc;
   assign s_stb   = s_cyc & m_stb[owner];
   assign s_we    = m_we[owner];
   assign s_adr   = m_adr[owner];
   assign s_dat_w = m_dat_w[owner];
   assign s_sel   = m_sel[owner];
   assign m_dat_r = s_dat_r;
   assign resp    = s_ack | s_err;
   assign inc     = s_stb & ~s_stall;
   assign dec     = busy & resp;

   always_comb begin
      m_stall        = '1;
      m_ack          = '0;
      m_err          = '0;
      m_stall[owner] = busy ? s_stall : 1'b1;
      m_ack[owner]   = busy & s_ack;
      m_err[owner]   = busy ? s_err : (abort & timeout_pulse);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         owner         <= '0;
         last_owner    <= LW'(NUM_MASTERS - 1);
         outstanding   <= '0;
         tcount        <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            IDLE: if (|m_cyc) begin
               state <= BUSY;
               grant <= pick;
               owner <= pick_idx;
            end
            BUSY: if (!own_cyc) begin
               state       <= IDLE;
               grant       <= '0;
               last_owner  <= owner;
               outstanding <= '0;
               tcount      <= '0;
            end else begin
               if (inc && !dec && outstanding != '1) outstanding <= outstanding + 1'b1;
               else if (dec && !inc && outstanding != '0) outstanding <= outstanding - 1'b1;
               if (resp || outstanding == '0) tcount <= '0;
               else begin
                  tcount <= tcount + 1'b1;
                  // abort on the edge where the count reaches the limit
                  if (TIMEOUT_CYCLES != 0 && tcount + 1'b1 == TLIM) begin
                     state         <= ABORT;
                     timeout_pulse <= 1'b1;
                  end
               end
            end
            ABORT: if (!own_cyc) begin
               state       <= IDLE;
               grant       <= '0;
               last_owner  <= owner;
               outstanding <= '0;
               tcount      <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
